bidirectional_port: RTL and testbench
=====================================

Name: bidirectional_port

Overview:
- Tri-state bidirectional pad buffer between core logic and a shared single-driver line.
- Drives the line from `data_out` when `direction` = 1.
- Releases the line (high-Z) and reads it back as input when `direction` = 0.
- A clocked monitor captures received data, flags contention and counts direction turnarounds.

Parameters:
- WIDTH, 1, bit width of `data_line`, `data_out`, `data_in`, `data_in_q`.
- CNT_W, 8, width of the turnaround counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_line  inout  WIDTH  shared bidirectional line.
- direction  input  1  1 = output mode (drive), 0 = input mode (release).
- data_out  input  WIDTH  value driven onto `data_line` in output mode.
- data_in  output  WIDTH  combinational read-back of `data_line`.
- data_in_q  output  WIDTH  registered sample of `data_line` taken in input mode.
- in_valid  output  1  one-cycle pulse when `data_in_q` is updated.
- drive_en  output  1  current output-enable (equals `direction`).
- contention  output  1  sticky contention flag.
- contention_clr  input  1  synchronous clear of `contention`.
- turn_cnt  output  CNT_W  count of output-to-input transitions.

Behaviour:
- Drive path is purely combinational: `data_line` = `direction` ? `data_out` : all-Z.
  - No clock dependence.
  - Release on `direction` falling happens in the same evaluation, so an external driver enabling 1 time unit later sees no overlap.
- `data_in` = `data_line` continuously, in both modes. In output mode it echoes `data_out`.
- `drive_en` = `direction`, combinational.
- Reset (`rst_n` = 0, asynchronous):
  - `data_in_q` = 0, `in_valid` = 0, `contention` = 0, `turn_cnt` = 0.
  - Register state of `direction` = 0.
  - Combinational paths (`data_line`, `data_in`, `drive_en`) are unaffected by reset.
- Input capture, each rising `clk` edge:
  - If `direction` = 0: `data_in_q` <= sampled `data_line`; `in_valid` <= 1.
  - Otherwise `data_in_q` holds and `in_valid` <= 0.
  - Latency: 1 cycle from line to `data_in_q`.
- Contention, each rising `clk` edge with `direction` = 1:
  - If `data_line` differs from `data_out` (any bit; X/Z on the line counts as a difference), set `contention`.
  - `contention` stays set until `contention_clr` = 1 at a clock edge.
  - If set and clear occur at the same edge, set wins.
- Turnaround counter:
  - A registered copy `dir_q` of `direction` is kept.
  - When `dir_q` = 1 and `direction` = 0 at an edge, `turn_cnt` increments.
  - Wraps modulo 2^CNT_W.
- Reset asserted mid-operation: registered outputs clear immediately; the line continues to follow `direction`.

Optional Feature:
- Macro: BIDIR_SYNC_IN_EN.
- Defined:
  - `data_line` passes through a 2-flop synchronizer (reset to 0) before `data_in_q` capture and before the contention compare.
  - `data_in_q` latency becomes 3 cycles.
  - Contention uses the synchronized value compared against `data_out` delayed by 2 cycles.
  - `in_valid` is qualified by `direction` delayed by 2 cycles.
- Undefined: direct sampling as described above, 1-cycle latency.
- `data_in` stays combinational in both builds.

Test Plan:
- Output mode: `direction`=1, external released, `data_out`=0 then 1 (10 time units each) -> `data_line`=0 then 1; `data_in`=0 then 1; `contention`=0.
- Input mode: `direction`=0, external drives 0 then 1 -> `data_line`/`data_in` follow 0 then 1; after the next clk edge `data_in_q`=1 and `in_valid` pulses.
- Turnaround: `direction`=1, `data_out`=1; then `direction`=0 and external drives 0 one time unit later -> `data_line` Z in the gap, then 0; no X; `contention`=0; `turn_cnt` increments by 1.
- Contention: `direction`=1, `data_out`=1, external drives 0 across a clk edge -> `contention`=1. It remains 1 after the external driver is released. `contention_clr`=1 for one cycle -> 0.
- Repeated transitions: 4 cycles of output(random `data_out`) / input(random external value) -> `data_line` matches the active driver each phase; `turn_cnt`=4; `data_in_q` equals the last external value.
- Reset mid-run: assert `rst_n`=0 with `contention`=1 and `turn_cnt`=3 -> both 0 immediately; `data_line` still driven while `direction`=1.

Source files
------------

// File: rtl/bidirectional_port.sv
// Tri-state pad buffer between core logic and a shared single-driver line.
// It drives the line from data_out when direction = 1. It releases the line
// and reads it back when direction = 0. A clocked monitor captures received
// data, flags contention and counts output-to-input turnarounds.
// Optional build macro: BIDIR_SYNC_IN_EN. When defined, the line passes
// through a two-flop synchronizer before capture and before the contention
// compare.
module bidirectional_port #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] data_line,
  input  logic             direction,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_in_q,
  output logic             in_valid,
  output logic             drive_en,
  output logic             contention,
  input  logic             contention_clr,
  output logic [CNT_W-1:0] turn_cnt
);

  // The drive path is purely combinational. Release happens in the same
  // evaluation as the fall of direction.
  assign data_line = direction ? data_out : {WIDTH{1'bz}};
  assign data_in   = data_line;
  assign drive_en  = direction;

  logic             dir_q;
  logic [WIDTH-1:0] line_s;   // line value seen by the monitor
  logic [WIDTH-1:0] ref_s;    // value expected on the line when driving
  logic             drive_s;  // drive mode aligned with line_s

`ifdef BIDIR_SYNC_IN_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] dout1_q, dout2_q;
  logic             dir1_q, dir2_q;

  // Two-flop synchronizer for the line. data_out and direction get matching
  // delays so that the compare lines up with the synchronized line value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      dir1_q  <= 1'b0;
      dir2_q  <= 1'b0;
    end else begin
      sync1_q <= data_line;
      sync2_q <= sync1_q;
      dout1_q <= data_out;
      dout2_q <= dout1_q;
      dir1_q  <= direction;
      dir2_q  <= dir1_q;
    end
  end

  assign line_s  = sync2_q;
  assign ref_s   = dout2_q;
  assign drive_s = dir2_q;
`else
  assign line_s  = data_line;
  assign ref_s   = data_out;
  assign drive_s = direction;
`endif

  // Capture the line in input mode and pulse in_valid when data_in_q updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_q <= '0;
      in_valid  <= 1'b0;
    end else if (!drive_s) begin
      data_in_q <= line_s;
      in_valid  <= 1'b1;
    end else begin
      in_valid  <= 1'b0;
    end
  end

  // Sticky contention flag. Case inequality makes X or Z on the line count
  // as a mismatch. A set wins over a clear at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
    end else if (drive_s && (line_s !== ref_s)) begin
      contention <= 1'b1;
    end else if (contention_clr) begin
      contention <= 1'b0;
    end
  end

  // Count output-to-input transitions of direction. The counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= 1'b0;
      turn_cnt <= '0;
    end else begin
      dir_q <= direction;
      if (dir_q && !direction) begin
        turn_cnt <= turn_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bidirectional_port.sv
// Directed bench for bidirectional_port in the default build (WIDTH = 1, CNT_W = 8).
// An external tri-state driver shares data_line with the DUT.
module tb_bidirectional_port;

  logic       clk;
  logic       rst_n;
  wire  [0:0] data_line;
  logic       direction;
  logic [0:0] data_out;
  logic [0:0] data_in;
  logic [0:0] data_in_q;
  logic       in_valid;
  logic       drive_en;
  logic       contention;
  logic       contention_clr;
  logic [7:0] turn_cnt;

  logic       ext_en;
  logic [0:0] ext_val;
  logic [0:0] last_ext;
  logic [0:0] rnd;

  int checks = 0;
  int errors = 0;

  assign data_line = ext_en ? ext_val : 1'bz;

  bidirectional_port #(
    .WIDTH(1),
    .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_line     (data_line),
    .direction     (direction),
    .data_out      (data_out),
    .data_in       (data_in),
    .data_in_q     (data_in_q),
    .in_valid      (in_valid),
    .drive_en      (drive_en),
    .contention    (contention),
    .contention_clr(contention_clr),
    .turn_cnt      (turn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge so that the outputs are sampled after it.
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    direction      = 1'b0;
    data_out       = 1'b0;
    contention_clr = 1'b0;
    ext_en         = 1'b0;
    ext_val        = 1'b0;
    last_ext       = 1'b0;
    #2;
    check("rst_data_in_q", 32'(data_in_q), 0);
    check("rst_in_valid", 32'(in_valid), 0);
    check("rst_contention", 32'(contention), 0);
    check("rst_turn_cnt", 32'(turn_cnt), 0);
    check("rst_drive_en", 32'(drive_en), 0);
    rst_n = 1'b1;

    // Output mode: the line follows data_out.
    direction = 1'b1;
    data_out  = 1'b0;
    #1;
    check("out0_line", 32'(data_line), 0);
    check("out0_data_in", 32'(data_in), 0);
    check("out_drive_en", 32'(drive_en), 1);
    data_out = 1'b1;
    #1;
    check("out1_line", 32'(data_line), 1);
    check("out1_data_in", 32'(data_in), 1);
    wait_edge();
    check("out_contention", 32'(contention), 0);
    check("out_in_valid", 32'(in_valid), 0);

    // Input mode: the external driver owns the line. This is turnaround 1.
    direction = 1'b0;
    ext_en    = 1'b1;
    ext_val   = 1'b0;
    #1;
    check("in0_data_in", 32'(data_in), 0);
    ext_val = 1'b1;
    #1;
    check("in1_line", 32'(data_line), 1);
    check("in1_data_in", 32'(data_in), 1);
    wait_edge();
    check("in_data_in_q", 32'(data_in_q), 1);
    check("in_valid_pulse", 32'(in_valid), 1);
    check("in_turn_cnt", 32'(turn_cnt), 1);
    ext_en    = 1'b0;
    direction = 1'b1;
    data_out  = 1'b1;
    #1;
    check("back_out_line", 32'(data_line), 1);
    wait_edge();
    check("in_valid_drop", 32'(in_valid), 0);
    check("data_in_q_hold", 32'(data_in_q), 1);
    check("back_contention", 32'(contention), 0);

    // Turnaround with the external driver enabled one time unit after release.
    direction = 1'b0;
    #1;
    ext_en  = 1'b1;
    ext_val = 1'b0;
    #1;
    check("turn_line", 32'(data_line), 0);
    check("turn_data_in", 32'(data_in), 0);
    wait_edge();
    check("turn_cnt_2", 32'(turn_cnt), 2);
    check("turn_contention", 32'(contention), 0);
    check("turn_data_in_q", 32'(data_in_q), 0);

    // Contention: the DUT drives 0 while the external driver drives 1.
    ext_en    = 1'b0;
    direction = 1'b1;
    data_out  = 1'b0;
    ext_en    = 1'b1;
    ext_val   = 1'b1;
    wait_edge();
    check("cont_set", 32'(contention), 1);
    ext_en = 1'b0;
    wait_edge();
    check("cont_sticky", 32'(contention), 1);
    contention_clr = 1'b1;
    wait_edge();
    contention_clr = 1'b0;
    check("cont_clr", 32'(contention), 0);
    // A set and a clear at the same edge: the set wins.
    ext_en         = 1'b1;
    contention_clr = 1'b1;
    wait_edge();
    check("cont_set_wins", 32'(contention), 1);
    ext_en = 1'b0;
    wait_edge();
    contention_clr = 1'b0;
    check("cont_clr2", 32'(contention), 0);

    // Four output and input phases with random values. turn_cnt goes 2 -> 6.
    for (int i = 0; i < 4; i++) begin
      ext_en    = 1'b0;
      direction = 1'b1;
      rnd       = 1'($urandom_range(0, 1));
      data_out  = rnd;
      #1;
      check("rep_out_line", 32'(data_line), 32'(rnd));
      wait_edge();
      direction = 1'b0;
      ext_en    = 1'b1;
      rnd       = 1'($urandom_range(0, 1));
      ext_val   = rnd;
      last_ext  = rnd;
      #1;
      check("rep_in_line", 32'(data_line), 32'(rnd));
      wait_edge();
    end
    check("rep_turn_cnt", 32'(turn_cnt), 6);
    check("rep_data_in_q", 32'(data_in_q), 32'(last_ext));
    check("rep_contention", 32'(contention), 0);

    // Reset mid-run after building up turn_cnt = 3 and contention = 1.
    ext_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst2_turn_cnt", 32'(turn_cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      direction = 1'b1;
      wait_edge();
      direction = 1'b0;
      wait_edge();
    end
    direction = 1'b1;
    data_out  = 1'b0;
    ext_en    = 1'b1;
    ext_val   = 1'b1;
    wait_edge();
    ext_en   = 1'b0;
    data_out = 1'b1;
    #1;
    check("pre_rst_turn_cnt", 32'(turn_cnt), 3);
    check("pre_rst_contention", 32'(contention), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_contention", 32'(contention), 0);
    check("mid_rst_turn_cnt", 32'(turn_cnt), 0);
    check("mid_rst_in_valid", 32'(in_valid), 0);
    check("mid_rst_data_in_q", 32'(data_in_q), 0);
    check("mid_rst_line", 32'(data_line), 1);
    check("mid_rst_drive_en", 32'(drive_en), 1);
    rst_n = 1'b1;
    wait_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
